// File: rtl/csp_sync_sink.sv
// csp_sync_sink: clocked receiver for a 4-phase bundled-data channel; stores tokens in a FIFO.
// Latency: l_req rise -> l_ack/FIFO write after SYNC_STAGES+1 edges; l_req fall -> l_ack fall after SYNC_STAGES+1 edges.
// Backpressure: when the FIFO is full l_ack is withheld, stalling the sender; output is valid/ready.
//
// Ports:
//   clk, rst_n            single clock (rising edge), async active-low reset
//   l_req, l_data, l_ack  4-phase channel; l_req is asynchronous, l_ack is a flop
//   out_valid/out_ready   stream handshake for the registered FIFO head out_data
//   count                 FIFO occupancy
//   rx_count              total accepted tokens, wraps at 16 bits
module csp_sync_sink #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       l_req,
  input  logic [WIDTH-1:0]           l_data,
  output logic                       l_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                rx_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  // Request synchronizer; only req_s is ever looked at.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  state_t                 state_q;
  logic                   l_ack_q;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          left_after_rd;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [15:0]            rx_count_q;

  logic                   wr_en;
  logic                   rd_en;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], l_req};
    end
  end

  // The full test uses pre-edge occupancy: a read on the same edge does not
  // make room for this edge's capture.
  assign wr_en = (state_q == ST_IDLE) && req_s && (count_q != DEPTH_C);
  assign rd_en = out_valid_q && out_ready;

  // Handshake FSM; l_ack is a registered output of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      l_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_en) begin
            state_q <= ST_CAPTURE;
            l_ack_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_WAIT_LOW;
          l_ack_q <= 1'b1;
        end
        ST_WAIT_LOW: begin
          if (!req_s) begin
            state_q <= ST_IDLE;
            l_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          l_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Next FIFO state and the new registered head.
  always_comb begin
    wr_ptr_d      = wr_ptr_q + PW'(wr_en);
    rd_ptr_d      = rd_ptr_q + PW'(rd_en);
    count_d       = count_q + CW'(wr_en) - CW'(rd_en);
    left_after_rd = count_q - CW'(rd_en);
    out_valid_d   = (count_d != '0);
    out_data_d    = out_data_q;
    if (count_d != '0) begin
      // When nothing older remains, the head is the token written on this
      // very edge, which is not yet in mem_q.
      if (wr_en && (left_after_rd == '0)) begin
        out_data_d = l_data;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rx_count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= l_data;
        rx_count_q      <= rx_count_q + 16'd1;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign l_ack     = l_ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_csp_sync_sink.sv
module tb_csp_sync_sink;

  logic        clk;
  logic        rst_n;
  logic        l_req;
  logic [7:0]  l_data;
  logic        l_ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  count;
  logic [15:0] rx_count;

  int checks = 0;
  int errors = 0;

  csp_sync_sink #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l_req     (l_req),
    .l_data    (l_data),
    .l_ack     (l_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .rx_count  (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  exp_count;
    logic [15:0] exp_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    l_req     = 1'b0;
    l_data    = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input logic v, input string name);
    int n;
    n = 0;
    while (l_ack !== v && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(l_ack), 32'(v));
  endtask

  task automatic send_token(input logic [7:0] d);
    l_data = d;
    l_req  = 1'b1;
    wait_ack(1'b1, "ack_rise");
    l_req = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  logic [7:0] stream_exp [24];
  int         got;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    tbl[0] = '{8'h10, 3'd1, 16'd1};
    tbl[1] = '{8'h20, 3'd2, 16'd2};
    tbl[2] = '{8'h30, 3'd3, 16'd3};
    tbl[3] = '{8'h40, 3'd4, 16'd4};
    tbl[4] = '{8'h5A, 3'd1, 16'd5};
    tbl[5] = '{8'h6B, 3'd2, 16'd6};
    tbl[6] = '{8'h7C, 3'd3, 16'd7};
    tbl[7] = '{8'h8D, 3'd4, 16'd8};
    for (int i = 0; i < 24; i++) stream_exp[i] = 8'((i * 37) + 5);

    // Reset state
    do_reset();
    check("rst_l_ack", 32'(l_ack), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_count", 32'(count), 0);
    check("rst_rx_count", 32'(rx_count), 0);

    // Single token, exact latency
    out_ready = 1'b1;
    l_data    = 8'hA5;
    l_req     = 1'b1;
    tick();
    tick();
    check("single_ack_early", 32'(l_ack), 0);
    tick();
    check("single_ack", 32'(l_ack), 1);
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_count", 32'(count), 1);
    tick();
    check("single_valid_gone", 32'(out_valid), 0);
    check("single_data_hold", 32'(out_data), 32'hA5);
    check("single_count_0", 32'(count), 0);
    l_req = 1'b0;
    tick();
    tick();
    check("single_ack_hold", 32'(l_ack), 1);
    tick();
    check("single_ack_fall", 32'(l_ack), 0);
    check("single_rx", 32'(rx_count), 1);

    // Back-pressure
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send_token(8'(i));
      check("bp_count", 32'(count), 32'(i));
    end
    l_data = 8'd5;
    l_req  = 1'b1;
    repeat (8) tick();
    check("bp_ack_held", 32'(l_ack), 0);
    check("bp_full", 32'(count), 4);
    check("bp_head", 32'(out_data), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_after_read_data", 32'(out_data), 2);
    check("bp_after_read_count", 32'(count), 3);
    check("bp_no_passthrough", 32'(l_ack), 0);
    tick();
    check("bp_capture_ack", 32'(l_ack), 1);
    check("bp_capture_count", 32'(count), 4);
    check("bp_rx", 32'(rx_count), 5);
    l_req = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");

    // Drain order twice: second pass runs over wrapped pointers
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_token(tbl[i].data);
      check("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      check("tbl_rx", 32'(rx_count), 32'(tbl[i].exp_rx));
      if (i % 4 == 3) begin
        out_ready = 1'b1;
        for (int k = i - 3; k <= i; k++) begin
          check("drain_valid", 32'(out_valid), 1);
          check("drain_data", 32'(out_data), 32'(tbl[k].data));
          tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 0);
        check("drain_count", 32'(count), 0);
      end
    end

    // Simultaneous write and read at count=2
    do_reset();
    send_token(8'h21);
    send_token(8'h22);
    l_data = 8'h23;
    l_req  = 1'b1;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("simul_ack", 32'(l_ack), 1);
    check("simul_count", 32'(count), 2);
    check("simul_head", 32'(out_data), 32'h22);
    l_req = 1'b0;
    wait_ack(1'b0, "simul_ack_fall");
    out_ready = 1'b1;
    check("simul_d0", 32'(out_data), 32'h22);
    tick();
    check("simul_d1", 32'(out_data), 32'h23);
    tick();
    check("simul_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Reset in WAIT_LOW with count=3
    do_reset();
    send_token(8'h31);
    send_token(8'h32);
    l_data = 8'h33;
    l_req  = 1'b1;
    wait_ack(1'b1, "mid_ack");
    tick();
    check("mid_count3", 32'(count), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(l_ack), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_rx", 32'(rx_count), 0);
    l_data = 8'h77;
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_ack_early", 32'(l_ack), 0);
    tick();
    check("mid_recap_ack", 32'(l_ack), 1);
    check("mid_recap_count", 32'(count), 1);
    check("mid_recap_data", 32'(out_data), 32'h77);
    check("mid_recap_rx", 32'(rx_count), 1);
    l_req = 1'b0;
    wait_ack(1'b0, "mid_ack_fall");

    // Streaming with a randomly stalling consumer
    do_reset();
    got = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send_token(stream_exp[i]);
        end
      end
      begin
        for (int c = 0; c < 4000 && got < 24; c++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            check("stream_data", 32'(out_data), 32'(stream_exp[got]));
            got++;
          end
        end
      end
    join
    out_ready = 1'b0;
    check("stream_got", 32'(got), 24);
    check("stream_rx", 32'(rx_count), 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
